kp_scanner: RTL
===============

# kp_scanner

Drives and reads a 4x4 matrix keypad: walks an active-low column strobe, samples the synchronised row lines, debounces a single pressed key and presents its 4-bit code on `d` with a qualifying `ena`. It is the source side of the keypad path and feeds the downstream keypad latch. That latch captures `d` on the falling edge of `ena`, so `d` must be stable across and after every `ena` fall.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven before its rows are sampled; legal range 3 or more.
- `DEB_CNT`, default 4: number of consecutive identical samples needed to accept a press or a release; legal range 1 to 255.
- `REPEAT_CNT`, default 250: number of held samples between auto-repeat re-strobes; used only when the macro in Configuration is defined.

- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `row`  in  4: keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col`  out  4: column strobes, active-low, exactly one bit low at any time.
- `d`  out  4: key code, equal to row_idx*4 + col_idx.
- `ena`  out  1: high while a debounced key is held.

## Operation
- Reset values: `col`=4'b1110 (column 0), `d`=0, `ena`=0, state SCAN, all counters 0.
- `row` passes through a 2-flop synchroniser. A "sample" is the synchronised row value taken on the last cycle of each SCAN_DIV window.
- A row sample is valid when exactly one bit is low.
- All-high means no key. Two or more low bits are treated as no key (ghost rejection).
- SCAN state:
  - A valid sample records row_idx and col_idx, sets the debounce count to 1, and moves to DEBOUNCE.
  - Any other sample advances the column, wrapping from column 3 to column 0.
- DEBOUNCE state: the column stays fixed.
  - A sample identical to the recorded one increments the count.
  - When the count reaches DEB_CNT, the block loads `d`, sets `ena`=1 and moves to HELD.
  - A differing sample advances the column and returns to SCAN.
  - With DEB_CNT=1, the block goes directly from SCAN to HELD.
- HELD state: the column stays fixed; changes to other keys are ignored.
  - An all-high sample increments the release count; any other sample clears it.
  - When the release count reaches DEB_CNT, `ena` goes to 0 and the state moves to RELEASE.
- RELEASE state: lasts one cycle. It advances the column and returns to SCAN.
- `d` changes only on the HELD entry cycle, i.e. the same edge on which `ena` rises. It holds its value indefinitely otherwise, including across and after `ena` falling.
- Counters saturate and never wrap. The window counter restarts on every state change.

## Timing
- Press latency from a `row` edge to `ena` rising: 2 synchroniser cycles, plus the remainder of the current window, plus (DEB_CNT-1)*SCAN_DIV, plus 1 cycle.
- Release latency: `ena` falls 1 cycle after the DEB_CNT-th consecutive all-high sample.
- Minimum `ena` low time between presses is 1 + SCAN_DIV cycles.
- When `rst_n` is asserted in any state, including HELD, outputs go immediately to their reset values. `ena` falling on reset is acceptable and produces a latch capture of the current `d`.
- A key pressed exactly while its column is being switched is seen on the next visit to that column.

## Configuration
- `KP_SCAN_REPEAT_EN` defined: in HELD, after every REPEAT_CNT consecutive held samples, `ena` is driven 0 for exactly one cycle and then returns to 1. `d` is unchanged, so the latch re-captures the same code. The repeat counter clears on HELD entry.
- `KP_SCAN_REPEAT_EN` undefined: `ena` produces exactly one rise and one fall per debounced press, and REPEAT_CNT is ignored.

## Structure
- Package `kp_pkg` holds:
  - NUM_ROWS=4, NUM_COLS=4 and KEY_W=4;
  - the state enum (SCAN, DEBOUNCE, HELD, RELEASE);
  - a function converting a one-cold row vector to an index plus a valid flag.
- Sub-module `kp_sync`: a parameterised-width 2-flop synchroniser for `row`, with asynchronous active-low reset to all-ones.

## Test plan
(SCAN_DIV=4, DEB_CNT=3)
- Reset with `row`=4'hF: `col`=4'b1110, `d`=0, `ena`=0. The column then steps 1110 → 1101 → 1011 → 0111 → 1110, changing every 4 cycles.
- Hold row 2 low while column 1 is strobed: `ena` rises with `d`=4'd9. The column stays at 1101 while the key is held.
- Release that key: `ena` falls after 3 all-high samples. `d` stays 9 for at least 20 cycles afterwards.
- Bounce by pulsing row 2 low for a single sample only: `ena` stays 0 and scanning resumes from column 2.
- Hold rows 1 and 3 low together: no `ena`, and scanning continues.
- Assert `rst_n` low during HELD: `ena`=0, `d`=0 and `col`=1110 immediately. With `KP_SCAN_REPEAT_EN` and REPEAT_CNT=2, a held key instead produces a 1-cycle low pulse on `ena` every 8 cycles while `d` stays constant.

Source files
------------

// File: rtl/kp_pkg.sv
// Shared keypad definitions: matrix size, scanner states, one-cold row decode.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package kp_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } kp_state_t;

    typedef struct packed {
        logic       vld;    // exactly one row line low
        logic [1:0] idx;    // index of the low row line
    } row_dec_t;

    // A row vector is only usable when exactly one line is low; all-high
    // is "no key" and two or more low lines are ghosting, both invalid.
    function automatic row_dec_t row_decode(input logic [NUM_ROWS-1:0] r);
        row_dec_t res;
        int       zeros;
        res   = '0;
        zeros = 0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!r[i]) begin
                zeros   = zeros + 1;
                res.idx = 2'(i);
            end
        end
        res.vld = (zeros == 1);
        return res;
    endfunction

endpackage

// File: rtl/kp_scanner_if.sv
// Keypad bundle: row sense lines in, column strobes plus key code/enable out.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer latches d on the falling edge of ena.
//
// Ports (master = scanner side):
//   row  in  active-low row sense lines, asynchronous to the scanner clock
//   col  out active-low column strobes, one-cold
//   d    out key code row_idx*4 + col_idx
//   ena  out high while a debounced key is held
interface kp_scanner_if;
    import kp_pkg::*;

    logic [NUM_ROWS-1:0] row;
    logic [NUM_COLS-1:0] col;
    logic [KEY_W-1:0]    d;
    logic                ena;

    modport master (input row, output col, output d, output ena);
    modport slave  (output row, input col, input d, input ena);
endinterface

// File: rtl/kp_sync.sv
// Two-flop synchroniser for a bus of independent asynchronous level signals.
// Latency: 2 clk cycles from din to dout.
// Backpressure: none; samples every cycle.
//
// Ports: clk, rst_n (async active-low, resets to all-ones = keys released),
//        din (asynchronous input), dout (synchronised output).
module kp_sync
    import kp_pkg::*;
#(
    parameter int W = NUM_ROWS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            dout <= '1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/kp_scanner.sv
// 4x4 keypad scanner: strobes columns, debounces one key, presents code on d with ena.
// Latency: press = 2 sync + window remainder + (DEB_CNT-1)*SCAN_DIV + 1 cycles to ena rise.
// Backpressure: none; downstream latch captures d on ena fall, d never changes then.
//
// Ports: clk, rst_n (async active-low), kp (kp_scanner_if.master: row in, col/d/ena out).
// Parameters: SCAN_DIV (cycles per column window, >=3), DEB_CNT (1..255 matching samples),
//             REPEAT_CNT (held samples between auto-repeat strobes).
// Optional feature macro: KP_SCAN_REPEAT_EN enables auto-repeat ena pulses while held.
module kp_scanner
    import kp_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_CNT    = 4,
    parameter int REPEAT_CNT = 250
) (
    input  logic         clk,
    input  logic         rst_n,
    kp_scanner_if.master kp
);

    localparam int WW = $clog2(SCAN_DIV);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    kp_state_t           state;
    logic [WW-1:0]       wcnt;
    logic [NUM_ROWS-1:0] row_s;
    logic [NUM_ROWS-1:0] rec_row;
    logic [1:0]          row_idx;
    logic [1:0]          col_idx;
    logic [NUM_COLS-1:0] col_q;
    logic [KEY_W-1:0]    d_q;
    logic                ena_q;
    logic [7:0]          deb_cnt;
    logic [7:0]          rel_cnt;
    logic [7:0]          deb_inc;
    logic [7:0]          rel_inc;
    logic                sample;
    logic                all_high;
    row_dec_t            dec;

    kp_sync #(.W(NUM_ROWS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (kp.row),
        .dout  (row_s)
    );

    // The sample is the synchronised rows on the last cycle of a window, which
    // leaves at least one settled cycle after the column strobe changed.
    assign sample   = (wcnt == WW'(SCAN_DIV - 1));
    assign dec      = row_decode(row_s);
    assign all_high = (row_s == '1);
    assign deb_inc  = sat_inc8(deb_cnt);
    assign rel_inc  = sat_inc8(rel_cnt);

`ifdef KP_SCAN_REPEAT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] rep_cnt;
    logic [15:0] rep_inc;
    assign rep_inc = sat_inc16(rep_cnt);
`else
    logic unused_rep;
    assign unused_rep = ^REPEAT_CNT;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SCAN;
            wcnt    <= '0;
            rec_row <= '1;
            row_idx <= '0;
            col_idx <= '0;
            col_q   <= 4'b1110;
            d_q     <= '0;
            ena_q   <= 1'b0;
            deb_cnt <= '0;
            rel_cnt <= '0;
`ifdef KP_SCAN_REPEAT_EN
            rep_cnt <= '0;
`endif
        end else begin
            wcnt <= sample ? '0 : wcnt + 1'b1;
            case (state)
                SCAN: begin
                    if (sample) begin
                        if (dec.vld) begin
                            rec_row <= row_s;
                            row_idx <= dec.idx;
                            deb_cnt <= 8'd1;
                            if (DEB_CNT <= 1) begin
                                // Single-sample debounce: accept immediately.
                                d_q     <= {dec.idx, col_idx};
                                ena_q   <= 1'b1;
                                rel_cnt <= '0;
`ifdef KP_SCAN_REPEAT_EN
                                rep_cnt <= '0;
`endif
                                state   <= HELD;
                            end else begin
                                state   <= DEBOUNCE;
                            end
                        end else begin
                            col_q   <= {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
                            col_idx <= col_idx + 2'd1;
                        end
                    end
                end

                DEBOUNCE: begin
                    if (sample) begin
                        if (row_s == rec_row) begin
                            deb_cnt <= deb_inc;
                            if (deb_inc >= 8'(DEB_CNT)) begin
                                d_q     <= {row_idx, col_idx};
                                ena_q   <= 1'b1;
                                rel_cnt <= '0;
`ifdef KP_SCAN_REPEAT_EN
                                rep_cnt <= '0;
`endif
                                state   <= HELD;
                            end
                        end else begin
                            col_q   <= {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
                            col_idx <= col_idx + 2'd1;
                            state   <= SCAN;
                        end
                    end
                end

                HELD: begin
`ifdef KP_SCAN_REPEAT_EN
                    // Repeat strobe lasts one cycle; a window is always >= 3
                    // cycles so this never collides with the next sample.
                    if (!ena_q) ena_q <= 1'b1;
`endif
                    if (sample) begin
                        rel_cnt <= all_high ? rel_inc : 8'd0;
                        if (all_high && rel_inc >= 8'(DEB_CNT)) begin
                            ena_q <= 1'b0;
                            state <= RELEASE;
                        end
`ifdef KP_SCAN_REPEAT_EN
                        else if (!all_high) begin
                            if (rep_inc >= 16'(REPEAT_CNT)) begin
                                ena_q   <= 1'b0;
                                rep_cnt <= '0;
                            end else begin
                                rep_cnt <= rep_inc;
                            end
                        end else begin
                            rep_cnt <= '0;
                        end
`endif
                    end
                end

                RELEASE: begin
                    wcnt    <= '0;
                    col_q   <= {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
                    col_idx <= col_idx + 2'd1;
                    state   <= SCAN;
                end

                default: begin
                    wcnt  <= '0;
                    state <= SCAN;
                end
            endcase
        end
    end

    assign kp.col = col_q;
    assign kp.d   = d_q;
    assign kp.ena = ena_q;

endmodule
